mod_counter: RTL and testbench

- Parametrised up/down modulo counter. It is the general-purpose successor to the fixed 2-bit counter used by the Maxnet controller.
- Counts within 0..MODULUS-1 in a configurable width, with synchronous init, parallel load and enable.
- Supports a wrap or saturate mode selected at run time.
- Provides a combinational terminal-count flag and a registered wrap pulse, used for neuron-index and iteration counting in the Maxnet datapath/controller.

---
 rtl/mod_counter.sv | 114 +++++++++++
 tb/tb_mod_counter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - parametrised up/down modulo counter with wrap/saturate modes
//
// Counts within 0..MODULUS-1. Synchronous priority: init > ld > en > hold.
// Optional sticky overflow flag is compiled in with `define MOD_COUNTER_STICKY_OVF_EN.
//
// Ports:
//   clk   in   1      rising-edge clock
//   rst   in   1      asynchronous active-high reset
//   init  in   1      synchronous clear to 0
//   ld    in   1      synchronous load of prl (clamped to MODULUS-1)
//   en    in   1      count enable
//   up    in   1      1 = increment, 0 = decrement
//   sat   in   1      1 = saturate at terminal, 0 = wrap modulo MODULUS
//   prl   in   WIDTH  parallel load value
//   out   out  WIDTH  current count (registered)
//   co    out  1      terminal count in the current direction (combinational)
//   wrap  out  1      registered pulse, high the cycle after a wrap
//   ovf   out  1      sticky terminal-hit flag (only with MOD_COUNTER_STICKY_OVF_EN)

module mod_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             ld,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] prl,
  output logic [WIDTH-1:0] out,
  output logic             co,
`ifdef MOD_COUNTER_STICKY_OVF_EN
  output logic             wrap,
  output logic             ovf
`else
  output logic             wrap
`endif
);

  // Highest legal count. When MODULUS == 2**WIDTH this is all ones and the
  // wrap is ordinary overflow, but it is still detected explicitly below.
  localparam logic [WIDTH-1:0] TERM = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             at_term;

  // Terminal in the current direction; shared by co, the wrap decision and ovf.
  always_comb begin
    at_term = up ? (out_q == TERM) : (out_q == '0);
  end

  always_comb begin
    out_d  = out_q;
    wrap_d = 1'b0;
    if (init) begin
      out_d = '0;
    end else if (ld) begin
      out_d = (prl > TERM) ? TERM : prl;
    end else if (en) begin
      if (at_term) begin
        // Saturate mode leaves out unchanged; wrap mode jumps to the far end.
        if (!sat) begin
          out_d  = up ? '0 : TERM;
          wrap_d = 1'b1;
        end
      end else begin
        out_d = up ? (out_q + WIDTH'(1)) : (out_q - WIDTH'(1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
  assign co   = at_term;

`ifdef MOD_COUNTER_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  // Set on any edge where the count is acted upon at the terminal, whether
  // it wraps or saturates. Only rst or init clear it; ld leaves it alone.
  always_comb begin
    ovf_d = ovf_q;
    if (init) begin
      ovf_d = 1'b0;
    end else if (!ld && en && at_term) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - scoreboard bench for mod_counter (MODULUS=10 and MODULUS=16 instances)

module tb_mod_counter;

  localparam int MA = 10;
  localparam int MB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init = 1'b0, ld = 1'b0, en = 1'b0, up = 1'b1, sat = 1'b0;
  logic [3:0] prl = 4'd0;
  logic [3:0] out_a, out_b;
  logic       co_a, co_b, wrap_a, wrap_b;

  always #5 clk = ~clk;

  mod_counter #(.WIDTH(4), .MODULUS(MA)) dut_a (
    .clk(clk), .rst(rst), .init(init), .ld(ld), .en(en), .up(up), .sat(sat),
    .prl(prl), .out(out_a), .co(co_a), .wrap(wrap_a)
  );

  mod_counter #(.WIDTH(4), .MODULUS(MB)) dut_b (
    .clk(clk), .rst(rst), .init(init), .ld(ld), .en(en), .up(up), .sat(sat),
    .prl(prl), .out(out_b), .co(co_b), .wrap(wrap_b)
  );

  typedef struct {
    int oa;
    bit wa;
    int ob;
    bit wb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: the count each instance should hold right now.
  int cnt_a = 0;
  int cnt_b = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Next count and wrap flag for a modulo-m counter, derived from the
  // behavioural rules with plain modular arithmetic.
  function automatic void model_next(input int m, input int cnt,
                                     input bit i_init, input bit i_ld, input bit i_en,
                                     input bit i_up, input bit i_sat, input int i_prl,
                                     output int ncnt, output bit nwrap);
    int stepped;
    ncnt  = cnt;
    nwrap = 1'b0;
    if (i_init) begin
      ncnt = 0;
    end else if (i_ld) begin
      ncnt = (i_prl > m - 1) ? m - 1 : i_prl;
    end else if (i_en) begin
      stepped = i_up ? (cnt + 1) % m : (cnt + m - 1) % m;
      if ((i_up && cnt == m - 1) || (!i_up && cnt == 0)) begin
        if (!i_sat) begin
          ncnt  = stepped;
          nwrap = 1'b1;
        end
      end else begin
        ncnt = stepped;
      end
    end
  endfunction

  // Called at a falling edge: applies inputs, checks co (and the immediate
  // effect of rst), queues the expected post-edge state, then moves to the
  // next falling edge.
  task automatic step(input bit i_rst, input bit i_init, input bit i_ld, input bit i_en,
                      input bit i_up, input bit i_sat, input int i_prl);
    exp_t e;
    rst  = i_rst;
    init = i_init;
    ld   = i_ld;
    en   = i_en;
    up   = i_up;
    sat  = i_sat;
    prl  = 4'(i_prl);
    #1;
    if (i_rst) begin
      cnt_a = 0;
      cnt_b = 0;
      chk("rst_out_a", int'(out_a), 0);
      chk("rst_wrap_a", int'(wrap_a), 0);
      chk("rst_out_b", int'(out_b), 0);
      chk("rst_wrap_b", int'(wrap_b), 0);
    end
    chk("co_a", int'(co_a), int'(i_up ? (cnt_a == MA - 1) : (cnt_a == 0)));
    chk("co_b", int'(co_b), int'(i_up ? (cnt_b == MB - 1) : (cnt_b == 0)));
    if (i_rst) begin
      e.oa = 0; e.wa = 1'b0; e.ob = 0; e.wb = 1'b0;
    end else begin
      model_next(MA, cnt_a, i_init, i_ld, i_en, i_up, i_sat, i_prl, e.oa, e.wa);
      model_next(MB, cnt_b, i_init, i_ld, i_en, i_up, i_sat, i_prl, e.ob, e.wb);
    end
    cnt_a = e.oa;
    cnt_b = e.ob;
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: the counter presents a new state every cycle, so compare one
  // queued expectation shortly after each rising edge.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_a", int'(out_a), e.oa);
        chk("wrap_a", int'(wrap_a), int'(e.wa));
        chk("out_b", int'(out_b), e.ob);
        chk("wrap_b", int'(wrap_b), int'(e.wb));
      end
    end
  end

  initial begin : driver
    @(negedge clk);
    step(1, 0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 0, 1, 0, 0);

    // Count up through a full cycle of the 16-state counter and beyond.
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 1, 0, 0);

    // Count down from 0 in wrap mode.
    step(0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 0, 0);

    // Clamped load, then saturate at the top.
    step(0, 0, 1, 0, 1, 0, 13);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 1, 0);
    // Saturate at the bottom.
    step(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 1, 0);

    // Priority: init beats ld and en; ld beats en.
    step(0, 0, 1, 0, 1, 0, 3);
    step(0, 1, 1, 1, 1, 0, 5);
    step(0, 0, 1, 1, 1, 0, 5);

    // Mid-cycle asynchronous reset at out=7, then resume counting.
    step(0, 0, 1, 0, 1, 0, 7);
    step(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 1, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           1'($urandom),
           int'($urandom_range(0, 15)));
    end

    step(0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
